// File: rtl/tdc_capture.sv
// rtl/tdc_capture.sv - delay-line TDC: launch, capture, 2-flop sync, thermometer encode, averaging.
// Optional bubble-correcting majority filter enabled by macro TDC_CAPTURE_BUBBLE_EN.

module cinv (
    input  logic a_i,
    output logic y_o
);
    assign y_o = ~a_i;
endmodule

module tdc_capture #(
    parameter  int N_TAPS    = 32,
    parameter  int N_STG     = 12,
    parameter  int AVG_LOG2  = 2,
    parameter  int DRAIN_MAX = 15,
    localparam int CW        = $clog2(N_TAPS + 1),
    localparam int RW        = CW + AVG_LOG2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_data,
    output logic          res_sat,
    output logic          res_err
);
    localparam int N_CELLS = N_TAPS * N_STG;
    localparam int SW      = AVG_LOG2 + 1;
    localparam int N_SHOT  = 1 << AVG_LOG2;
    localparam int DW      = $clog2(DRAIN_MAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_CAPT   = 3'd2;
    localparam logic [2:0] S_SYNC   = 3'd3;
    localparam logic [2:0] S_ENC    = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_OUT    = 3'd6;

    logic [2:0]        state_q, state_d;
    logic              launch_q;
    logic [N_TAPS-1:0] taps_w;
    logic [N_TAPS-1:0] cap_q, sync_q, enc_in;
    logic [SW-1:0]     shots_q, shots_d;
    logic [RW-1:0]     acc_q, acc_d;
    logic              sat_q, sat_d, err_q, err_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              fresh_q, fresh_d;
    logic [CW-1:0]     code;
    logic              run;

    // Each cell gets its own net so the chain is not seen as one self-looping vector.
    for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
        (* keep *) logic y;
        if (i == 0) begin : g_first
            (* keep *) cinv u_cinv (.a_i(launch_q), .y_o(y));
        end else begin : g_next
            (* keep *) cinv u_cinv (.a_i(g_cell[i-1].y), .y_o(y));
        end
    end

    for (genvar t = 0; t < N_TAPS; t++) begin : g_tap
        assign taps_w[t] = g_cell[(t + 1) * N_STG - 1].y;
    end

    always_comb begin
        enc_in = sync_q;
`ifdef TDC_CAPTURE_BUBBLE_EN
        for (int k = 1; k < N_TAPS - 1; k++) begin
            enc_in[k] = (sync_q[k-1] & sync_q[k]) | (sync_q[k] & sync_q[k+1])
                      | (sync_q[k-1] & sync_q[k+1]);
        end
`endif
    end

    always_comb begin
        code = '0;
        run  = 1'b1;
        for (int k = 0; k < N_TAPS; k++) begin
            if (run && enc_in[k]) begin
                code = CW'(k + 1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        shots_d = shots_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        err_d   = err_q;
        drain_d = drain_q;
        fresh_d = fresh_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    shots_d = '0;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    err_d   = 1'b0;
                    drain_d = '0;
                    fresh_d = 1'b0;
                    // After reset the chain state is unknown, so check it clears first.
                    state_d = fresh_q ? S_DRAIN : S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_CAPT;
            S_CAPT:   state_d = S_SYNC;
            S_SYNC:   state_d = S_ENC;
            S_ENC: begin
                acc_d   = acc_q + RW'(code);
                sat_d   = sat_q | (code == CW'(N_TAPS));
                shots_d = shots_q + 1'b1;
                drain_d = '0;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if ((cap_q == '0) || (drain_q == DW'(DRAIN_MAX - 1))) begin
                    if (cap_q != '0) begin
                        err_d = 1'b1;
                    end
                    state_d = (shots_q < SW'(N_SHOT)) ? S_LAUNCH : S_OUT;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            launch_q <= 1'b0;
            cap_q    <= '0;
            sync_q   <= '0;
            shots_q  <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
            err_q    <= 1'b0;
            drain_q  <= '0;
            fresh_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            launch_q <= (state_d == S_LAUNCH);
            // Hold the launch capture through CAPT so SYNC sees it; sample freely otherwise.
            if (state_q != S_CAPT) begin
                cap_q <= taps_w;
            end
            if (state_q == S_CAPT) begin
                sync_q <= cap_q;
            end
            shots_q  <= shots_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
            err_q    <= err_d;
            drain_q  <= drain_d;
            fresh_q  <= fresh_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign res_valid = (state_q == S_OUT);
    assign res_data  = acc_q;
    assign res_sat   = sat_q;
    assign res_err   = err_q;

endmodule

// File: tb/tb_tdc_capture.sv
// tb/tb_tdc_capture.sv - directed and randomized bench for tdc_capture with a reference model.

module tb_tdc_capture;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_sat;
    logic       res_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mode    = 0;
    int          pidx    = 0;
    logic [31:0] pats [4];
    logic [31:0] tap_ovr;

    tdc_capture dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_sat   (res_sat),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    // Mode 1: present the shot's pattern on the taps only while launch is high.
    always @(dut.launch_q) begin
        if (mode == 1) begin
            if (dut.launch_q) begin
                tap_ovr = pats[pidx % 4];
                pidx++;
                force dut.taps_w = tap_ovr;
            end else begin
                release dut.taps_w;
            end
        end
    end

    function automatic int model_code(input logic [31:0] p);
        logic [31:0] q;
        int          c;
        q = p;
`ifdef TDC_CAPTURE_BUBBLE_EN
        for (int k = 1; k < 31; k++) begin
            q[k] = (int'(p[k-1]) + int'(p[k]) + int'(p[k+1])) >= 2;
        end
`endif
        c = 0;
        while (c < 32 && q[c]) c++;
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(output int lat);
        @(negedge clk);
        cmd_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            cmd_valid = 1'b0;
        end while (!res_valid && lat < 300);
    endtask

    task automatic pop(input int hold);
        repeat (hold) @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic check_res(input string tag, input int lat, input int exp_lat,
                             input int exp_data, input bit exp_sat, input bit exp_err);
        check({tag, "_lat"},  64'(lat), 64'(exp_lat));
        check({tag, "_data"}, 64'(res_data), 64'(exp_data));
        check({tag, "_sat"},  64'(res_sat), 64'(exp_sat));
        check({tag, "_err"},  64'(res_err), 64'(exp_err));
    endtask

    initial begin
        int          lat;
        int          bad;
        int          sum;
        int          c;
        int          bi;
        bit          sat;
        logic [7:0]  d0;
        logic [31:0] p;

        repeat (3) @(negedge clk);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_data",  64'(res_data),  64'd0);
        check("rst_sat",   64'(res_sat),   64'd0);
        check("rst_err",   64'(res_err),   64'd0);
        check("rst_launch", 64'(dut.launch_q), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(cmd_ready), 64'd1);

        // Zero-delay chain: every tap is set during launch, so each shot saturates.
        run_cmd(lat);
        check_res("natural", lat, 1 + 4 * 5 + 1, 4 * 32, 1'b1, 1'b0);

        cmd_valid = 1'b1;
        d0  = res_data;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!res_valid || res_data !== d0 || cmd_ready !== 1'b0) bad++;
        end
        check("hold_stable", 64'(bad), 64'd0);
        res_ready = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("pop_valid", 64'(res_valid), 64'd0);
        check("pop_ready", 64'(cmd_ready), 64'd1);

        mode = 1;
        pidx = 0;
        for (int i = 0; i < 4; i++) pats[i] = 32'h0000_00FF;
        run_cmd(lat);
        check_res("ff", lat, 4 * 5 + 1, 32, 1'b0, 1'b0);
        pop(0);

        pidx = 0;
        for (int i = 0; i < 4; i++) pats[i] = 32'h0000_00F7;
        run_cmd(lat);
        check_res("bubble", lat, 4 * 5 + 1, 4 * model_code(32'h0000_00F7), 1'b0, 1'b0);
        pop(1);

        mode = 0;
        tap_ovr = 32'h0000_00FF;
        force dut.taps_w = tap_ovr;
        run_cmd(lat);
        check_res("drain_to", lat, 4 * (4 + 15) + 1, 32, 1'b0, 1'b1);
        release dut.taps_w;
        pop(2);

        mode = 1;
        for (int r = 0; r < 6; r++) begin
            pidx = 0;
            sum  = 0;
            sat  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                c = $urandom_range(0, 32);
                p = (c == 32) ? 32'hFFFF_FFFF : ((32'd1 << c) - 32'd1);
                if ($urandom_range(0, 1) == 1) begin
                    bi = $urandom_range(0, 31);
                    p[bi] = ~p[bi];
                end
                pats[i] = p;
                sum += model_code(p);
                if (model_code(p) == 32) sat = 1'b1;
            end
            run_cmd(lat);
            check_res($sformatf("rand%0d", r), lat, 4 * 5 + 1, sum, sat, 1'b0);
            pop($urandom_range(0, 3));
        end

        mode = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("shot2_launch", 64'(dut.launch_q), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_launch", 64'(dut.launch_q), 64'd0);
        check("abort_valid",  64'(res_valid),    64'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (res_valid) bad++;
        end
        check("abort_no_res", 64'(bad), 64'd0);
        run_cmd(lat);
        check_res("post_rst", lat, 1 + 4 * 5 + 1, 128, 1'b1, 1'b0);
        pop(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
